mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
Main control FSM for the multi-cycle MIPS32 datapath. It sits directly upstream of the ALU-control decoder and supplies its 2-bit ALUOp. Each cycle it sequences fetch, decode, execute, memory and writeback by driving datapath enables and mux selects. It is a Moore machine: outputs are a pure function of the current state, except illegal_op, which is combinational from state and opcode.

Parameters:
OP_RTYPE, 6'b000000, R-type opcode
OP_LW, 6'b100011, load word
OP_SW, 6'b101011, store word
OP_BEQ, 6'b000100, branch if equal
OP_J, 6'b000010, jump
OP_ADDI, 6'b001000, add immediate
FN_JR, 6'b001000, funct code for jr

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high
opcode  in  6  IR[31:26], valid from DECODE onward
funct  in  6  IR[5:0]
state  out  4  current state (debug/verification)
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load qualified by ALU zero (beq)
IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
MemRead  out  1  memory read
MemWrite  out  1  memory write
MemtoReg  out  1  writeback data select: 0 = ALUOut, 1 = MDR
IRWrite  out  1  instruction register load
RegDst  out  1  destination register select: 0 = rt, 1 = rd
RegWrite  out  1  register file write
ALUSrcA  out  1  ALU A select: 0 = PC, 1 = A
ALUSrcB  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
ALUOp  out  2  to ALU-control decoder: 00 = add, 01 = sub (branch), 10 = use funct
PCSource  out  2  next-PC select: 00 = ALU, 01 = ALUOut, 10 = jump target, 11 = register A (jr)
illegal_op  out  1  high in DECODE when opcode/funct is unsupported

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset:
  - While reset is high: state = FETCH (4'd0).
  - While reset is high, every output except state is forced to 0 (combinational gate). No write or PC update can occur during reset.
  - The first FETCH actions happen on the first clock edge after reset deasserts.
  - Asserting reset mid-instruction abandons the instruction immediately.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BEQ 8, JUMP 9, ADDI_EX 10, ADDI_WB 11, JR 12. Encodings 13-15 go to FETCH with all outputs 0.
- Output defaults: every output is 0 unless listed for the state below.
  - FETCH: MemRead, IRWrite, PCWrite, ALUSrcB = 01, ALUOp = 00, PCSource = 00.
  - DECODE: ALUSrcB = 11, ALUOp = 00.
  - MEMADR: ALUSrcA, ALUSrcB = 10, ALUOp = 00.
  - MEMRD: MemRead, IorD.
  - MEMWB: RegWrite, MemtoReg, RegDst = 0.
  - MEMWR: MemWrite, IorD.
  - EXEC: ALUSrcA, ALUOp = 10.
  - RWB: RegWrite, RegDst.
  - BEQ: ALUSrcA, ALUOp = 01, PCWriteCond, PCSource = 01.
  - JUMP: PCWrite, PCSource = 10.
  - ADDI_EX: ALUSrcA, ALUSrcB = 10, ALUOp = 00.
  - ADDI_WB: RegWrite (RegDst = 0, MemtoReg = 0).
  - JR: PCWrite, PCSource = 11.
- Transitions:
  - FETCH -> DECODE.
  - DECODE, by opcode:
    - LW or SW -> MEMADR.
    - RTYPE with funct == FN_JR -> JR.
    - RTYPE with any other funct -> EXEC.
    - BEQ -> BEQ.
    - J -> JUMP.
    - ADDI -> ADDI_EX.
    - Anything else -> FETCH, with illegal_op = 1 for that DECODE cycle.
  - MEMADR -> MEMRD if opcode == LW, else MEMWR.
  - MEMRD -> MEMWB -> FETCH.
  - MEMWR -> FETCH.
  - EXEC -> RWB -> FETCH.
  - ADDI_EX -> ADDI_WB -> FETCH.
  - BEQ, JUMP, JR -> FETCH.
- opcode and funct are sampled only in DECODE and MEMADR. Changes in other states are ignored.
- Latency in cycles, FETCH through last state: lw 5; sw, R-type, addi 4; beq, j, jr 3.
- No handshake. Memory is single-cycle; no stall input.

Test Plan:
1. Reset held 3 cycles, then release with opcode = 100011 -> during reset all outputs 0 and state = 0. After release: states 0, 1, 2, 3, 4, 0. In state 4, RegWrite = 1 and MemtoReg = 1.
2. opcode = 000000, funct = 100000 -> states 0, 1, 6, 7, 0. ALUOp = 10 in state 6. RegDst = 1 and RegWrite = 1 in state 7.
3. opcode = 000000, funct = 001000 -> states 0, 1, 12, 0. PCSource = 11 and PCWrite = 1 in state 12. RegWrite stays 0 throughout.
4. opcode = 000100, then opcode = 000010 -> states 0, 1, 8 (ALUOp = 01, PCWriteCond = 1, PCSource = 01), then 0, 1, 9 (PCWrite = 1, PCSource = 10).
5. opcode = 111111 -> illegal_op = 1 only in DECODE, next state FETCH. No RegWrite or MemWrite is asserted.
6. sw (101011) with reset asserted asynchronously in MEMADR, mid-cycle -> state is 0 and MemWrite is 0 immediately, before the next edge. After release, normal fetch resumes.

Source files
------------

// File: rtl/mips_multicycle_ctrl_if.sv
// Bundle between the multi-cycle MIPS main controller and its datapath.
// The controller (master) receives the instruction fields from the IR and
// drives every enable and mux select. The datapath (slave) sees the reverse.
// Interface protocol: there is no valid/ready handshake. The memory is single-cycle
// and there is no stall. Every control output is meaningful in every cycle.
// opcode and funct are only looked at while the controller is in DECODE or MEMADR.
interface mips_multicycle_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic [3:0] state;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       MemtoReg;
  logic       IRWrite;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;
  logic       illegal_op;

  modport master (
    input  opcode, funct,
    output state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
           IRWrite, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           illegal_op
  );

  modport slave (
    output opcode, funct,
    input  state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
           IRWrite, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           illegal_op
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS32 datapath.
// Sequences fetch, decode, execute, memory and writeback. It is a Moore machine:
// outputs depend on the state only, except illegal_op, which also depends on opcode.
// While reset is high every control output is forced low, so nothing is written
// and the PC does not move.
module mips_multicycle_ctrl #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] FN_JR    = 6'b001000
) (
  input logic                  clk,
  input logic                  reset,
  mips_multicycle_ctrl_if.master bus
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXEC    = 4'd6;
  localparam logic [3:0] S_RWB     = 4'd7;
  localparam logic [3:0] S_BEQ     = 4'd8;
  localparam logic [3:0] S_JUMP    = 4'd9;
  localparam logic [3:0] S_ADDI_EX = 4'd10;
  localparam logic [3:0] S_ADDI_WB = 4'd11;
  localparam logic [3:0] S_JR      = 4'd12;

  // Ungated control word, decoded from the state alone.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  logic [3:0] r_state;
  logic [3:0] w_next_state;
  ctrl_t      w_ctrl;
  logic       w_op_legal;
  logic       w_illegal;
  logic       w_run;

  // An opcode is legal if DECODE has a dispatch target for it. Every R-type funct is accepted.
  assign w_op_legal = (bus.opcode == OP_RTYPE) || (bus.opcode == OP_LW) ||
                      (bus.opcode == OP_SW)    || (bus.opcode == OP_BEQ) ||
                      (bus.opcode == OP_J)     || (bus.opcode == OP_ADDI);

  // State register. Asynchronous reset returns to FETCH and abandons any instruction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next_state;
  end

  // Next-state logic. opcode is looked at only in DECODE and MEMADR, and funct only in DECODE.
  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_FETCH:   w_next_state = S_DECODE;
      S_DECODE: begin
        if (bus.opcode == OP_LW || bus.opcode == OP_SW) w_next_state = S_MEMADR;
        else if (bus.opcode == OP_RTYPE)
          w_next_state = (bus.funct == FN_JR) ? S_JR : S_EXEC;
        else if (bus.opcode == OP_BEQ)  w_next_state = S_BEQ;
        else if (bus.opcode == OP_J)    w_next_state = S_JUMP;
        else if (bus.opcode == OP_ADDI) w_next_state = S_ADDI_EX;
        else                            w_next_state = S_FETCH;
      end
      S_MEMADR:  w_next_state = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   w_next_state = S_MEMWB;
      S_MEMWB:   w_next_state = S_FETCH;
      S_MEMWR:   w_next_state = S_FETCH;
      S_EXEC:    w_next_state = S_RWB;
      S_RWB:     w_next_state = S_FETCH;
      S_BEQ:     w_next_state = S_FETCH;
      S_JUMP:    w_next_state = S_FETCH;
      S_ADDI_EX: w_next_state = S_ADDI_WB;
      S_ADDI_WB: w_next_state = S_FETCH;
      S_JR:      w_next_state = S_FETCH;
      default:   w_next_state = S_FETCH;
    endcase
  end

  // Moore output decode. Any signal not named for a state is 0. The unused encodings 13-15 give all zeros.
  always_comb begin
    w_ctrl = '0;
    case (r_state)
      S_FETCH: begin
        w_ctrl.mem_read  = 1'b1;
        w_ctrl.ir_write  = 1'b1;
        w_ctrl.pc_write  = 1'b1;
        w_ctrl.alu_src_b = 2'b01;
        w_ctrl.alu_op    = 2'b00;
        w_ctrl.pc_source = 2'b00;
      end
      S_DECODE: begin
        w_ctrl.alu_src_b = 2'b11;
        w_ctrl.alu_op    = 2'b00;
      end
      S_MEMADR: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = 2'b10;
        w_ctrl.alu_op    = 2'b00;
      end
      S_MEMRD: begin
        w_ctrl.mem_read = 1'b1;
        w_ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.iord      = 1'b1;
      end
      S_EXEC: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_op    = 2'b10;
      end
      S_RWB: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.reg_dst   = 1'b1;
      end
      S_BEQ: begin
        w_ctrl.alu_src_a     = 1'b1;
        w_ctrl.alu_op        = 2'b01;
        w_ctrl.pc_write_cond = 1'b1;
        w_ctrl.pc_source     = 2'b01;
      end
      S_JUMP: begin
        w_ctrl.pc_write  = 1'b1;
        w_ctrl.pc_source = 2'b10;
      end
      S_ADDI_EX: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = 2'b10;
        w_ctrl.alu_op    = 2'b00;
      end
      S_ADDI_WB: begin
        w_ctrl.reg_write = 1'b1;
      end
      S_JR: begin
        w_ctrl.pc_write  = 1'b1;
        w_ctrl.pc_source = 2'b11;
      end
      default: w_ctrl = '0;
    endcase
  end

  // illegal_op is the only output that is not Moore. It flags an unsupported opcode during DECODE.
  assign w_illegal = (r_state == S_DECODE) && !w_op_legal;

  // Reset gate. It acts immediately and does not wait for an edge, so an abandoned instruction cannot write anything.
  assign w_run = ~reset;

  assign bus.state       = r_state;
  assign bus.PCWrite     = w_run & w_ctrl.pc_write;
  assign bus.PCWriteCond = w_run & w_ctrl.pc_write_cond;
  assign bus.IorD        = w_run & w_ctrl.iord;
  assign bus.MemRead     = w_run & w_ctrl.mem_read;
  assign bus.MemWrite    = w_run & w_ctrl.mem_write;
  assign bus.MemtoReg    = w_run & w_ctrl.mem_to_reg;
  assign bus.IRWrite     = w_run & w_ctrl.ir_write;
  assign bus.RegDst      = w_run & w_ctrl.reg_dst;
  assign bus.RegWrite    = w_run & w_ctrl.reg_write;
  assign bus.ALUSrcA     = w_run & w_ctrl.alu_src_a;
  assign bus.ALUSrcB     = {2{w_run}} & w_ctrl.alu_src_b;
  assign bus.ALUOp       = {2{w_run}} & w_ctrl.alu_op;
  assign bus.PCSource    = {2{w_run}} & w_ctrl.pc_source;
  assign bus.illegal_op  = w_run & w_illegal;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Testbench for mips_multicycle_ctrl: a directed vector table, random instruction
// streams checked against a per-instruction state-path model, and mid-instruction reset.
module tb_mips_multicycle_ctrl;

  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3,
                         MEMWB = 4'd4, MEMWR = 4'd5, EXEC = 4'd6, RWB = 4'd7,
                         BEQ = 4'd8, JUMP = 4'd9, ADDI_EX = 4'd10, ADDI_WB = 4'd11,
                         JR = 4'd12;

  typedef struct packed {
    logic       pcw;
    logic       pcwc;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       m2r;
    logic       irw;
    logic       rdst;
    logic       rwr;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       ill;
  } ctrl_t;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    int          n;
    logic [19:0] seq;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [3:0] exp_q[$];
  ctrl_t exp_tab[16];
  vec_t  vecs[8];
  ctrl_t dut_ctrl;

  mips_multicycle_ctrl_if bus ();

  mips_multicycle_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign dut_ctrl = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                     bus.MemtoReg, bus.IRWrite, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
                     bus.ALUSrcB, bus.ALUOp, bus.PCSource, bus.illegal_op};

  // Clock and reset.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic is_legal(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
  endfunction

  // Reference model. It lists the state path one instruction takes, starting at FETCH.
  task automatic model_push(input logic [5:0] op, input logic [5:0] fn);
    exp_q.push_back(FETCH);
    exp_q.push_back(DECODE);
    case (op)
      6'b100011: begin exp_q.push_back(MEMADR); exp_q.push_back(MEMRD); exp_q.push_back(MEMWB); end
      6'b101011: begin exp_q.push_back(MEMADR); exp_q.push_back(MEMWR); end
      6'b000000: begin
        if (fn == 6'b001000) exp_q.push_back(JR);
        else begin exp_q.push_back(EXEC); exp_q.push_back(RWB); end
      end
      6'b000100: exp_q.push_back(BEQ);
      6'b000010: exp_q.push_back(JUMP);
      6'b001000: begin exp_q.push_back(ADDI_EX); exp_q.push_back(ADDI_WB); end
      default: ;
    endcase
  endtask

  task automatic chk_state(input string nm, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: state got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic chk_ctrl(input string nm, input ctrl_t got, input ctrl_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: ctrl got %h expected %h", nm, got, exp);
    end
  endtask

  // Driver. It pops up to 'steps' expected states and checks each cycle. The real
  // instruction fields are present only in DECODE and MEMADR. Other states get random junk.
  task automatic run_seq(input string nm, input logic [5:0] op, input logic [5:0] fn,
                         input int steps);
    logic [3:0] s;
    ctrl_t e;
    for (int i = 0; i < steps && exp_q.size() > 0; i++) begin
      s = exp_q.pop_front();
      if (s == DECODE || s == MEMADR) begin
        bus.opcode = op;
        bus.funct  = fn;
      end else begin
        bus.opcode = 6'($urandom);
        bus.funct  = 6'($urandom);
      end
      e = exp_tab[s];
      if (s == DECODE) e.ill = !is_legal(op);
      #1;
      chk_state(nm, bus.state, s);
      chk_ctrl(nm, dut_ctrl, e);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    ctrl_t zero;
    logic [5:0] op, fn;
    int sel;
    checks = 0;
    errors = 0;
    zero   = '0;

    // Expected control word for each state.
    for (int i = 0; i < 16; i++) exp_tab[i] = '0;
    exp_tab[FETCH].mrd = 1; exp_tab[FETCH].irw = 1; exp_tab[FETCH].pcw = 1;
    exp_tab[FETCH].srcb = 2'b01;
    exp_tab[DECODE].srcb = 2'b11;
    exp_tab[MEMADR].srca = 1; exp_tab[MEMADR].srcb = 2'b10;
    exp_tab[MEMRD].mrd = 1; exp_tab[MEMRD].iord = 1;
    exp_tab[MEMWB].rwr = 1; exp_tab[MEMWB].m2r = 1;
    exp_tab[MEMWR].mwr = 1; exp_tab[MEMWR].iord = 1;
    exp_tab[EXEC].srca = 1; exp_tab[EXEC].aluop = 2'b10;
    exp_tab[RWB].rwr = 1; exp_tab[RWB].rdst = 1;
    exp_tab[BEQ].srca = 1; exp_tab[BEQ].aluop = 2'b01; exp_tab[BEQ].pcwc = 1;
    exp_tab[BEQ].pcsrc = 2'b01;
    exp_tab[JUMP].pcw = 1; exp_tab[JUMP].pcsrc = 2'b10;
    exp_tab[ADDI_EX].srca = 1; exp_tab[ADDI_EX].srcb = 2'b10;
    exp_tab[ADDI_WB].rwr = 1;
    exp_tab[JR].pcw = 1; exp_tab[JR].pcsrc = 2'b11;

    // Directed vectors: the state path is written as nibbles, with the first state in bits [3:0].
    vecs[0] = '{6'b100011, 6'b000000, 5, 20'h43210};
    vecs[1] = '{6'b101011, 6'b000000, 4, 20'h05210};
    vecs[2] = '{6'b000000, 6'b100000, 4, 20'h07610};
    vecs[3] = '{6'b000000, 6'b001000, 3, 20'h00C10};
    vecs[4] = '{6'b000100, 6'b000000, 3, 20'h00810};
    vecs[5] = '{6'b000010, 6'b000000, 3, 20'h00910};
    vecs[6] = '{6'b001000, 6'b001000, 4, 20'h0BA10};
    vecs[7] = '{6'b111111, 6'b101010, 2, 20'h00010};

    // Reset held for 3 cycles with lw on the inputs. Everything must read zero.
    reset      = 1'b1;
    bus.opcode = 6'b100011;
    bus.funct  = 6'b000000;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_state("reset_state", bus.state, FETCH);
      chk_ctrl("reset_ctrl", dut_ctrl, zero);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;

    // Table-driven vectors, run back to back.
    for (int v = 0; v < 8; v++) begin
      for (int k = 0; k < vecs[v].n; k++) exp_q.push_back(vecs[v].seq[4*k +: 4]);
      run_seq($sformatf("vec%0d", v), vecs[v].op, vecs[v].fn, 99);
    end

    // Asynchronous reset while sw sits in MEMADR. The instruction must be abandoned at once.
    exp_q.delete();
    model_push(6'b101011, 6'b000000);
    run_seq("sw_pre", 6'b101011, 6'b000000, 2);
    bus.opcode = 6'b101011;
    #1;
    chk_state("sw_memadr", bus.state, MEMADR);
    #1;
    reset = 1'b1;
    #1;
    chk_state("abort_state", bus.state, FETCH);
    chk_ctrl("abort_ctrl", dut_ctrl, zero);
    exp_q.delete();
    @(posedge clk);
    #1;
    chk_state("abort_hold", bus.state, FETCH);
    chk_ctrl("abort_hold_ctrl", dut_ctrl, zero);
    @(negedge clk);
    reset = 1'b0;
    #1;
    model_push(6'b100011, 6'b000000);
    run_seq("resume_lw", 6'b100011, 6'b000000, 99);

    // Random instruction stream checked against the model.
    for (int t = 0; t < 60; t++) begin
      sel = $urandom_range(0, 7);
      fn  = ($urandom_range(0, 3) == 0) ? 6'b001000 : 6'($urandom);
      case (sel)
        0: op = 6'b100011;
        1: op = 6'b101011;
        2: op = 6'b000000;
        3: op = 6'b000100;
        4: op = 6'b000010;
        5: op = 6'b001000;
        default: op = 6'($urandom);
      endcase
      model_push(op, fn);
      run_seq($sformatf("rand%0d_op%02h", t, op), op, fn, 99);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
